// File: rtl/blink_monitor.sv
// Measures the period of an asynchronous square wave in clk cycles, declares
// lock after LOCK_COUNT consecutive in-tolerance periods and flags a stuck input.
module blink_monitor #(
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned EXPECTED_FREQUENCY_IN_HZ    = 1,
    parameter int unsigned TOLERANCE_PERCENT           = 5,
    parameter int unsigned LOCK_COUNT                  = 2,
    localparam int unsigned EXPECTED_PERIOD = BOARD_CLOCK_FREQUENCY_IN_HZ / EXPECTED_FREQUENCY_IN_HZ,
    localparam int unsigned TOL             = EXPECTED_PERIOD * TOLERANCE_PERCENT / 100,
    localparam int unsigned TIMEOUT         = 2 * EXPECTED_PERIOD,
    localparam int unsigned PW              = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blink_in,
    output logic [PW-1:0] period_cycles,
    output logic          period_valid,
    output logic          locked,
    output logic          stuck,
    output logic [1:0]    state_dbg
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

    localparam logic [PW-1:0] TIMEOUT_C = PW'(TIMEOUT);
    localparam logic [PW-1:0] LO_C      = PW'(EXPECTED_PERIOD - TOL);
    localparam logic [PW-1:0] HI_C      = PW'(EXPECTED_PERIOD + TOL);
    localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_COUNT);

    // state_dbg encoding: 0 = IDLE, 1 = ARMED, 2 = LOCKED
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [PW-1:0] period_d;
    logic          valid_d, locked_d, stuck_d;

    logic          sync0, sync1, hist;
    logic          rise;
    logic [PW-1:0] cnt;
    logic          good;
    logic          timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync0 <= blink_in;
            sync1 <= sync0;
            hist  <= sync1;
        end
    end

    assign rise = sync1 & ~hist;

    // cnt equals the rise-to-rise distance on the cycle of the second rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= PW'(1);
        end else if (cnt != TIMEOUT_C) begin
            cnt <= cnt + PW'(1);
        end
    end

    assign good    = (cnt >= LO_C) && (cnt <= HI_C);
    assign timeout = (cnt == TIMEOUT_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            good_q        <= '0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
            locked        <= 1'b0;
            stuck         <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            period_cycles <= period_d;
            period_valid  <= valid_d;
            locked        <= locked_d;
            stuck         <= stuck_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = period_cycles;
        valid_d  = 1'b0;
        locked_d = locked;
        stuck_d  = stuck;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                    stuck_d = 1'b0;
                    good_d  = '0;
                end
            end
            ARMED: begin
                if (rise) begin
                    period_d = cnt;
                    valid_d  = 1'b1;
                    if (good) begin
                        good_d = good_q + GW'(1);
                        if (good_q + GW'(1) >= LOCK_C) begin
                            good_d   = LOCK_C;
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    state_d  = IDLE;
                    stuck_d  = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d = cnt;
                    valid_d  = 1'b1;
                    if (!good) begin
                        state_d  = ARMED;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end else if (timeout) begin
                    state_d  = IDLE;
                    stuck_d  = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                good_d   = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: an edge-timestamp model predicts every
// output each cycle; literal period lists and state checks pin the model.
module tb_blink_monitor;

    localparam int BOARD  = 1000;
    localparam int EXPF   = 10;
    localparam int EXP_P  = BOARD / EXPF;
    localparam int TOL_C  = EXP_P * 5 / 100;
    localparam int TMO    = 2 * EXP_P;
    localparam int LOCK_N = 2;
    localparam int PW     = $clog2(TMO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          blink_in = 1'b0;
    logic [PW-1:0] period_cycles;
    logic          period_valid;
    logic          locked;
    logic          stuck;
    logic [1:0]    state_dbg;

    blink_monitor #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(BOARD),
        .EXPECTED_FREQUENCY_IN_HZ   (EXPF),
        .TOLERANCE_PERCENT          (5),
        .LOCK_COUNT                 (LOCK_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blink_in     (blink_in),
        .period_cycles(period_cycles),
        .period_valid (period_valid),
        .locked       (locked),
        .stuck        (stuck),
        .state_dbg    (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // scoreboard: literal expected published periods, and model edge timestamps
    logic [PW-1:0] exp_q[$];
    int            edge_q[$];

    // driver tasks: inputs change 1 time unit after a rising clk edge
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // a rising blink_in after posedge k is visible on the outputs after posedge k+3
    task automatic drive(input logic v);
        if (v && !blink_in && !rst) edge_q.push_back(cyc + 3);
        blink_in = v;
    endtask

    task automatic wave(input int p);
        drive(1'b1);
        wait_cycles(p / 2);
        drive(1'b0);
        wait_cycles(p - p / 2);
    endtask

    // model: 0 = idle, 1 = armed, 2 = locked
    int   m_state  = 0;
    int   m_last   = 0;
    int   m_run    = 0;
    int   m_period = 0;
    int   m_p      = 0;
    bit   m_valid  = 0;
    bit   m_locked = 0;
    bit   m_stuck  = 0;
    bit   m_rise   = 0;

    always @(negedge clk) begin
        m_valid = 0;
        m_rise  = 0;
        if (rst) begin
            m_state  = 0;
            m_run    = 0;
            m_period = 0;
            m_locked = 0;
            m_stuck  = 0;
            edge_q.delete();
        end else begin
            if (edge_q.size() > 0 && edge_q[0] == cyc) begin
                void'(edge_q.pop_front());
                m_rise = 1;
            end
            if (m_rise) begin
                if (m_state == 0) begin
                    m_state = 1;
                    m_stuck = 0;
                    m_run   = 0;
                end else begin
                    m_p      = cyc - m_last;
                    m_period = m_p;
                    m_valid  = 1;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL exp_q_underrun @cyc %0d: got period %0d expected none", cyc, m_p);
                    end else begin
                        check("model_period", m_p, exp_q.pop_front());
                    end
                    if (m_p >= EXP_P - TOL_C && m_p <= EXP_P + TOL_C) begin
                        m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
                        if (m_run == LOCK_N) begin
                            m_locked = 1;
                            m_state  = 2;
                        end
                    end else begin
                        m_run    = 0;
                        m_locked = 0;
                        m_state  = 1;
                    end
                end
                m_last = cyc;
            end else if (m_state != 0 && cyc - m_last == TMO) begin
                m_state  = 0;
                m_stuck  = 1;
                m_locked = 0;
                m_run    = 0;
            end
        end
        check("period_valid",  period_valid,  m_valid);
        check("period_cycles", period_cycles, m_period);
        check("locked",        locked,        m_locked);
        check("stuck",         stuck,         m_stuck);
        check("state",         state_dbg,     m_state);
    end

    initial begin
        // reset with blink_in toggling
        for (int i = 0; i < 10; i++) begin
            drive(i[0]);
            wait_cycles(1);
        end
        check("rst_period", period_cycles, 0);
        check("rst_valid",  period_valid,  0);
        check("rst_locked", locked,        0);
        check("rst_stuck",  stuck,         0);
        drive(1'b0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(5);

        // first edge only arms
        wave(100);
        check("arm_state",  state_dbg,     1);
        check("arm_stuck",  stuck,         0);
        check("arm_period", period_cycles, 0);

        // nominal lock
        for (int i = 0; i < 4; i++) exp_q.push_back(PW'(100));
        wave(100);
        wave(100);
        check("nom_locked_2nd", locked, 1);
        wave(100);
        wave(100);
        check("nom_locked", locked, 1);

        // tolerance edges
        exp_q.push_back(PW'(100));
        exp_q.push_back(PW'(105));
        exp_q.push_back(PW'(95));
        exp_q.push_back(PW'(106));
        exp_q.push_back(PW'(100));
        exp_q.push_back(PW'(100));
        wave(105);
        wave(95);
        check("tol_105_locked", locked, 1);
        wave(106);
        check("tol_95_locked", locked, 1);
        wave(100);
        check("tol_106_drop", locked, 0);
        check("tol_106_val",  period_cycles, 106);
        wave(100);
        wave(100);
        check("tol_relock", locked, 1);

        // stuck input while locked
        exp_q.push_back(PW'(100));
        drive(1'b1);
        wait_cycles(50);
        drive(1'b0);
        wait_cycles(250);
        check("stuck_set",    stuck,     1);
        check("stuck_unlock", locked,    0);
        check("stuck_state",  state_dbg, 0);
        check("stuck_hold",   period_cycles, 100);
        wave(100);
        check("stuck_clear", stuck,     0);
        check("stuck_armed", state_dbg, 1);
        exp_q.push_back(PW'(100));
        exp_q.push_back(PW'(100));
        wave(100);
        check("stuck_one_good", locked, 0);
        wave(100);
        check("stuck_relock", locked, 1);

        // timeout tie: edge exactly TIMEOUT after the previous one
        exp_q.push_back(PW'(100));
        exp_q.push_back(PW'(200));
        drive(1'b1);
        wait_cycles(50);
        drive(1'b0);
        wait_cycles(150);
        drive(1'b1);
        wait_cycles(10);
        check("tie_period", period_cycles, 200);
        check("tie_stuck",  stuck,     0);
        check("tie_locked", locked,    0);
        check("tie_state",  state_dbg, 1);

        // relock, then asynchronous reset mid-operation
        wait_cycles(40);
        drive(1'b0);
        wait_cycles(50);
        exp_q.push_back(PW'(100));
        exp_q.push_back(PW'(100));
        wave(100);
        wave(100);
        check("pre_rst_locked", locked, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_period", period_cycles, 0);
        check("mid_rst_valid",  period_valid,  0);
        check("mid_rst_locked", locked,        0);
        check("mid_rst_stuck",  stuck,         0);
        drive(1'b0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5);
        exp_q.push_back(PW'(100));
        exp_q.push_back(PW'(100));
        wave(100);
        check("post_rst_arm", state_dbg, 1);
        wave(100);
        check("post_rst_one", locked, 0);
        wave(100);
        check("post_rst_relock", locked, 1);

        wait_cycles(10);
        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
